// File: rtl/vga_seq_pkg.sv
// Shared types and helpers for the VGA sequencer FML mux: sequencer state
// encoding, select-width helper and the von_pipe depth limit.
package vga_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DRAIN  = 2'd2,
    SWITCH = 2'd3
  } seq_state_e;

  localparam int PIPE_D_MAX = 8;

  function automatic int calc_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_seq_fml_req.sv
// FML read handshake: latches the active source address, holds the strobe until
// acknowledge and steers a one-cycle ack back to the active source.
module vga_seq_fml_req
  import vga_seq_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int ADR_W   = 17,
  parameter int SEL_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic [ADR_W-1:0]   i_adr,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic               i_fml_ack,
  output logic [ADR_W-1:0]   o_fml_adr,
  output logic               o_fml_stb,
  output logic [NUM_SRC-1:0] o_src_ack,
  output logic               o_busy
);

  seq_state_e         r_state, w_state_nxt;
  logic [ADR_W-1:0]   r_adr, w_adr_nxt;
  logic               r_stb, w_stb_nxt;
  logic [NUM_SRC-1:0] r_ack, w_ack_nxt;
  logic [NUM_SRC-1:0] w_onehot;

  // one-hot decode of the active source index
  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_onehot[k] = (i_sel == SEL_W'(k));
    end
  end

  // next-state logic; an ack with the request still pending chains straight into a new REQ
  always_comb begin
    w_state_nxt = r_state;
    w_adr_nxt   = r_adr;
    w_stb_nxt   = r_stb;
    w_ack_nxt   = '0;
    if (i_enable) begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            w_state_nxt = REQ;
            w_adr_nxt   = i_adr;
            w_stb_nxt   = 1'b1;
          end else begin
            w_stb_nxt   = 1'b0;
          end
        end
        REQ: begin
          if (i_fml_ack) begin
            w_ack_nxt = w_onehot;
            if (i_start) begin
              w_adr_nxt = i_adr;
            end else begin
              w_state_nxt = IDLE;
              w_stb_nxt   = 1'b0;
            end
          end else begin
            w_stb_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_stb_nxt   = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // state and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_stb   <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_adr   <= w_adr_nxt;
      r_stb   <= w_stb_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  assign o_fml_adr = r_adr;
  assign o_fml_stb = r_stb;
  assign o_src_ack = r_ack;
  assign o_busy    = (r_state == REQ);

endmodule

// File: rtl/vga_sequencer_mux_fml.sv
// Multi-source VGA sequencer output stage: FML read mux, pixel stream mux and
// vsync-deferred mode switching. Optional VGA_SEQ_FETCH_STATS_EN adds fetch stats.
module vga_sequencer_mux_fml
  import vga_seq_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int ADR_W   = 17,
  parameter int PIX_W   = 8,
  parameter int PIPE_D  = 2,
  parameter int SEL_W   = calc_sel_w(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [SEL_W-1:0]           mode_req_i,
  input  logic [NUM_SRC*ADR_W-1:0]   src_adr_i,
  input  logic [NUM_SRC-1:0]         src_stb_i,
  output logic [NUM_SRC-1:0]         src_ack_o,
  input  logic [NUM_SRC*PIX_W-1:0]   src_pix_i,
  input  logic [NUM_SRC-1:0]         src_hsync_i,
  input  logic [NUM_SRC-1:0]         src_von_h_i,
  input  logic                       video_on_h_i,
  input  logic                       video_on_v_i,
  input  logic                       vert_sync_i,
  output logic [ADR_W-1:0]           fml_adr_o,
  output logic                       fml_stb_o,
  input  logic                       fml_ack_i,
  output logic                       hsync_o,
  output logic                       vsync_o,
  output logic                       von_h_o,
  output logic                       von_v_o,
  output logic [PIX_W-1:0]           pix_o,
  output logic [SEL_W-1:0]           mode_o,
`ifdef VGA_SEQ_FETCH_STATS_EN
  output logic [15:0]                fetch_cnt_o,
  output logic                       underrun_o,
`endif
  output logic                       switch_pend_o
);

  localparam logic [SEL_W:0] LP_NSRC = (SEL_W + 1)'(NUM_SRC);

  seq_state_e        r_mstate, w_mstate_nxt;
  logic [SEL_W-1:0]  r_mode, w_mode_nxt;
  logic              r_pend, w_pend_nxt;
  logic              r_vs_d;
  logic [PIPE_D-1:0] r_von_pipe;
  logic              r_hsync, r_vsync, r_von_h, r_von_v;
  logic [PIX_W-1:0]  r_pix;

  logic              w_req_valid, w_vs_rise, w_gate, w_block, w_start, w_busy, w_quiet;
  logic              w_stb_sel, w_von_sel;
  logic [ADR_W-1:0]  w_adr_sel;

  assign w_req_valid = (mode_req_i != r_mode) && ({1'b0, mode_req_i} < LP_NSRC);
  assign w_vs_rise   = vert_sync_i & ~r_vs_d;
  assign w_stb_sel   = src_stb_i[r_mode];
  assign w_von_sel   = src_von_h_i[r_mode];
  assign w_adr_sel   = src_adr_i[r_mode*ADR_W +: ADR_W];
  assign w_gate      = (video_on_h_i | r_von_pipe[PIPE_D-1]) & video_on_v_i;
  // any pending or in-progress switch blocks new fetches
  assign w_block     = w_req_valid | r_pend | (r_mstate != IDLE);
  assign w_start     = w_stb_sel & w_gate & ~w_block;
  assign w_quiet     = (r_mstate == DRAIN) || (r_mstate == SWITCH);

  vga_seq_fml_req #(
    .NUM_SRC (NUM_SRC),
    .ADR_W   (ADR_W),
    .SEL_W   (SEL_W)
  ) u_fml_req (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_enable  (enable),
    .i_start   (w_start),
    .i_adr     (w_adr_sel),
    .i_sel     (r_mode),
    .i_fml_ack (fml_ack_i),
    .o_fml_adr (fml_adr_o),
    .o_fml_stb (fml_stb_o),
    .o_src_ack (src_ack_o),
    .o_busy    (w_busy)
  );

  // mode-switch sequencing: wait out the fetch, then the next vsync rise
  always_comb begin
    w_mstate_nxt = r_mstate;
    w_mode_nxt   = r_mode;
    w_pend_nxt   = r_pend;
    if (enable) begin
      case (r_mstate)
        IDLE: begin
          if (w_req_valid) begin
            w_pend_nxt = 1'b1;
            if (!w_busy) begin
              w_mstate_nxt = DRAIN;
            end else begin
              w_mstate_nxt = IDLE;
            end
          end else begin
            w_pend_nxt = 1'b0;
          end
        end
        DRAIN: begin
          if (!w_req_valid) begin
            w_mstate_nxt = IDLE;
            w_pend_nxt   = 1'b0;
          end else if (w_vs_rise) begin
            w_mstate_nxt = SWITCH;
          end else begin
            w_mstate_nxt = DRAIN;
          end
        end
        SWITCH: begin
          if (w_req_valid) begin
            w_mode_nxt = mode_req_i;
          end else begin
            w_mode_nxt = r_mode;
          end
          w_pend_nxt   = 1'b0;
          w_mstate_nxt = IDLE;
        end
        default: begin
          w_mstate_nxt = IDLE;
          w_pend_nxt   = 1'b0;
        end
      endcase
    end else begin
      w_mstate_nxt = r_mstate;
    end
  end

  // mode state registers and vsync edge delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstate <= IDLE;
      r_mode   <= '0;
      r_pend   <= 1'b0;
      r_vs_d   <= 1'b0;
    end else if (enable) begin
      r_mstate <= w_mstate_nxt;
      r_mode   <= w_mode_nxt;
      r_pend   <= w_pend_nxt;
      r_vs_d   <= vert_sync_i;
    end
  end

  // video_on_h delay pipe, flushed on a mode switch so the new source starts clean
  generate
    if (PIPE_D == 1) begin : g_pipe1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_von_pipe <= '0;
        end else if (enable) begin
          r_von_pipe <= (r_mstate == SWITCH) ? 1'b0 : w_von_sel;
        end
      end
    end else begin : g_pipen
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_von_pipe <= '0;
        end else if (enable) begin
          if (r_mstate == SWITCH) begin
            r_von_pipe <= '0;
          end else begin
            r_von_pipe <= {r_von_pipe[PIPE_D-2:0], w_von_sel};
          end
        end
      end
    end
  endgenerate

  // registered stream toward the DAC stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_von_h <= 1'b0;
      r_von_v <= 1'b0;
      r_pix   <= '0;
    end else if (enable) begin
      r_hsync <= src_hsync_i[r_mode];
      r_vsync <= vert_sync_i;
      r_von_v <= video_on_v_i;
      r_von_h <= w_quiet ? 1'b0 : w_von_sel;
      r_pix   <= w_quiet ? '0 : src_pix_i[r_mode*PIX_W +: PIX_W];
    end
  end

  assign hsync_o       = r_hsync;
  assign vsync_o       = r_vsync;
  assign von_h_o       = r_von_h;
  assign von_v_o       = r_von_v;
  assign pix_o         = r_pix;
  assign mode_o        = r_mode;
  assign switch_pend_o = r_pend;

`ifdef VGA_SEQ_FETCH_STATS_EN
  logic        w_ack_fire;
  logic [15:0] r_cnt, r_fetch_cnt;
  logic [4:0]  r_wait;
  logic        r_underrun;

  assign w_ack_fire = w_busy & fml_ack_i;

  // per-frame ack count and stalled-fetch detector, both rolled over at vsync rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_fetch_cnt <= '0;
      r_wait      <= '0;
      r_underrun  <= 1'b0;
    end else if (enable) begin
      if (w_vs_rise) begin
        r_fetch_cnt <= r_cnt + (w_ack_fire ? 16'd1 : 16'd0);
        r_cnt       <= '0;
        r_wait      <= '0;
        r_underrun  <= 1'b0;
      end else begin
        if (w_ack_fire) begin
          r_cnt <= r_cnt + 16'd1;
        end
        if (w_busy && w_gate && w_stb_sel && !w_ack_fire) begin
          if (r_wait != 5'd31) begin
            r_wait <= r_wait + 5'd1;
          end
          if (r_wait >= 5'd16) begin
            r_underrun <= 1'b1;
          end
        end else begin
          r_wait <= '0;
        end
      end
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign underrun_o  = r_underrun;
`endif

endmodule
